// File: rtl/fechadura_pkg.sv
// fechadura_pkg: shared types and constants for the lock setup logic.
// Digit packs hold the most recent digit in element [0]. A slot holding
// DIGIT_EMPTY means "no digit".
package fechadura_pkg;

    localparam int SENHA_DIGITS = 20;

    typedef logic [SENHA_DIGITS-1:0][3:0] senhaPac_t;
    typedef logic [5:0][3:0]              bcdPac_t;

    localparam logic [3:0] DIGIT_EMPTY = 4'hF;

    localparam senhaPac_t SENHA_EMPTY      = {SENHA_DIGITS{DIGIT_EMPTY}};
    // Factory master password: digits[3..0] = 1,2,3,4
    localparam senhaPac_t SENHA_MASTER_RST = {{(SENHA_DIGITS-4){DIGIT_EMPTY}},
                                              4'h1, 4'h2, 4'h3, 4'h4};
    localparam bcdPac_t   BCD_BLANK        = {6{DIGIT_EMPTY}};

    // Item codes shown on the leftmost display digit
    localparam logic [3:0] ITEM_BIP_ST    = 4'd1;
    localparam logic [3:0] ITEM_BIP_T     = 4'd2;
    localparam logic [3:0] ITEM_TRANCA_T  = 4'd3;
    localparam logic [3:0] ITEM_MASTER    = 4'd4;
    localparam logic [3:0] ITEM_USER      = 4'd5;

    // USER covers every user slot; the slot index lives in its own register
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIP_ST,
        ST_BIP_T,
        ST_TRANCA_T,
        ST_MASTER,
        ST_USER,
        ST_COMMIT
    } setup_state_t;

    // Two-digit decimal split of a 0..63 value: {tens, units}
    function automatic logic [7:0] to_bcd2(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

endpackage

// File: rtl/setup_pw_check.sv
// setup_pw_check: combinational inspection of an entered digit pack.
// len    - contiguous non-empty digits starting at the most recent one
// bad    - a non-decimal digit (0xA..0xE) appears within len
// masked - the entry with every digit at or beyond len forced empty
module setup_pw_check
    import fechadura_pkg::*;
(
    input  senhaPac_t  digits,
    output logic [4:0] len,
    output logic       bad,
    output senhaPac_t  masked
);

    logic run;

    // Walk from the most recent digit until the first empty slot
    always_comb begin
        len    = '0;
        bad    = 1'b0;
        masked = SENHA_EMPTY;
        run    = 1'b1;
        for (int i = 0; i < SENHA_DIGITS; i++) begin
            if (run && (digits[i] != DIGIT_EMPTY)) begin
                len       = len + 5'd1;
                masked[i] = digits[i];
                if (digits[i] > 4'd9) begin
                    bad = 1'b1;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/setup_multi.sv
// setup_multi: interactive configuration session for the lock.
// A session walks bip status, bip time, lock time, master password and each
// user password, editing a shadow copy; the committed outputs only change
// when the last user item is accepted.
// Optional build macro SETUP_DUP_CHECK_EN: reject a user password equal to
// the master or to another enabled user slot.
module setup_multi
    import fechadura_pkg::*;
#(
    parameter int N_USERS = 4,
    parameter int PW_MIN  = 4,
    parameter int PW_MAX  = 12,
    parameter int T_MIN   = 5,
    parameter int T_MAX   = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    setup_on,
    input  senhaPac_t               digitos_value,
    input  logic                    digitos_valid,
    output logic                    display_en,
    output bcdPac_t                 bcd_pac,
    output logic                    bip_status,
    output logic [5:0]              bip_time,
    output logic [5:0]              tranca_time,
    output senhaPac_t               senha_master,
    output senhaPac_t [N_USERS-1:0] senha_user,
    output logic                    data_setup_ok,
    output logic                    entry_err
);

    localparam int K_W = (N_USERS > 1) ? $clog2(N_USERS) : 1;

    setup_state_t state, state_nxt;
    logic [K_W-1:0] k, k_nxt;
    logic setup_on_q;

    logic                    sh_status, sh_status_nxt;
    logic [5:0]              sh_bt, sh_bt_nxt;
    logic [5:0]              sh_tt, sh_tt_nxt;
    senhaPac_t               sh_master, sh_master_nxt;
    senhaPac_t [N_USERS-1:0] sh_user, sh_user_nxt;

    logic       accept, reject, commit, dup;
    logic [4:0] ent_len;
    logic       ent_bad;
    senhaPac_t  ent_masked;
    logic [6:0] ent_val;
    logic       last_user, in_t_range, pw_len_ok;

    setup_pw_check u_pw_check (
        .digits (digitos_value),
        .len    (ent_len),
        .bad    (ent_bad),
        .masked (ent_masked)
    );

    // A one-digit time entry has an empty tens slot, so it counts as zero
    assign ent_val    = ((ent_len == 5'd2) ? 7'(digitos_value[1]) * 7'd10 : 7'd0)
                        + 7'(digitos_value[0]);
    assign in_t_range = (int'(ent_val) >= T_MIN) && (int'(ent_val) <= T_MAX);
    assign pw_len_ok  = (int'(ent_len) >= PW_MIN) && (int'(ent_len) <= PW_MAX);
    assign last_user  = (int'(k) == N_USERS - 1);

    // Duplicate detection against the shadow master and other enabled slots
    always_comb begin
        dup = 1'b0;
`ifdef SETUP_DUP_CHECK_EN
        if (ent_masked == sh_master) begin
            dup = 1'b1;
        end
        for (int j = 0; j < N_USERS; j++) begin
            if ((j != int'(k)) && (sh_user[j] != SENHA_EMPTY) && (ent_masked == sh_user[j])) begin
                dup = 1'b1;
            end
        end
`endif
    end

    function automatic bcdPac_t make_bcd(input setup_state_t st, input logic [K_W-1:0] kk,
                                         input logic status, input logic [5:0] bt,
                                         input logic [5:0] tt);
        bcdPac_t b;
        b = BCD_BLANK;
        case (st)
            ST_BIP_ST: begin
                b[5] = ITEM_BIP_ST;
                b[4] = 4'd0;
                b[1] = 4'd0;
                b[0] = {3'b000, status};
            end
            ST_BIP_T: begin
                b[5] = ITEM_BIP_T;
                b[4] = 4'd0;
                {b[1], b[0]} = to_bcd2(bt);
            end
            ST_TRANCA_T: begin
                b[5] = ITEM_TRANCA_T;
                b[4] = 4'd0;
                {b[1], b[0]} = to_bcd2(tt);
            end
            ST_MASTER: begin
                b[5] = ITEM_MASTER;
                b[4] = 4'd0;
            end
            ST_USER: begin
                b[5] = ITEM_USER;
                b[4] = 4'(kk) + 4'd1;
            end
            default: ;
        endcase
        return b;
    endfunction

    // Next-state, entry validation and shadow update
    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        sh_status_nxt = sh_status;
        sh_bt_nxt     = sh_bt;
        sh_tt_nxt     = sh_tt;
        sh_master_nxt = sh_master;
        sh_user_nxt   = sh_user;
        accept        = 1'b0;
        reject        = 1'b0;
        commit        = 1'b0;

        if (state == ST_IDLE) begin
            // Only a fresh rising edge opens a session, never a held level
            if (setup_on && !setup_on_q) begin
                state_nxt     = ST_BIP_ST;
                k_nxt         = '0;
                sh_status_nxt = bip_status;
                sh_bt_nxt     = bip_time;
                sh_tt_nxt     = tranca_time;
                sh_master_nxt = senha_master;
                sh_user_nxt   = senha_user;
            end
        end else if (!setup_on) begin
            state_nxt = ST_IDLE;
        end else if (state == ST_COMMIT) begin
            state_nxt = ST_IDLE;
        end else if (digitos_valid) begin
            if (ent_len == 5'd0) begin
                accept = 1'b1;
            end else if (!ent_bad) begin
                case (state)
                    ST_BIP_ST: begin
                        if ((ent_len == 5'd1) && (digitos_value[0] <= 4'd1)) begin
                            accept        = 1'b1;
                            sh_status_nxt = digitos_value[0][0];
                        end
                    end
                    ST_BIP_T: begin
                        if ((ent_len <= 5'd2) && in_t_range) begin
                            accept    = 1'b1;
                            sh_bt_nxt = ent_val[5:0];
                        end
                    end
                    ST_TRANCA_T: begin
                        if ((ent_len <= 5'd2) && in_t_range) begin
                            accept    = 1'b1;
                            sh_tt_nxt = ent_val[5:0];
                        end
                    end
                    ST_MASTER: begin
                        if (pw_len_ok) begin
                            accept        = 1'b1;
                            sh_master_nxt = ent_masked;
                        end
                    end
                    ST_USER: begin
                        // A lone 0 disables the slot
                        if ((ent_len == 5'd1) && (digitos_value[0] == 4'd0)) begin
                            accept         = 1'b1;
                            sh_user_nxt[k] = SENHA_EMPTY;
                        end else if (pw_len_ok && !dup) begin
                            accept         = 1'b1;
                            sh_user_nxt[k] = ent_masked;
                        end
                    end
                    default: ;
                endcase
            end

            reject = !accept;

            if (accept) begin
                case (state)
                    ST_BIP_ST:   state_nxt = ST_BIP_T;
                    ST_BIP_T:    state_nxt = ST_TRANCA_T;
                    ST_TRANCA_T: state_nxt = ST_MASTER;
                    ST_MASTER: begin
                        state_nxt = ST_USER;
                        k_nxt     = '0;
                    end
                    ST_USER: begin
                        if (last_user) begin
                            state_nxt = ST_COMMIT;
                            commit    = 1'b1;
                        end else begin
                            k_nxt = k + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM state, committed configuration and registered display/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            k             <= '0;
            setup_on_q    <= 1'b0;
            bip_status    <= 1'b1;
            bip_time      <= 6'd5;
            tranca_time   <= 6'd5;
            senha_master  <= SENHA_MASTER_RST;
            senha_user    <= {N_USERS{SENHA_EMPTY}};
            display_en    <= 1'b0;
            bcd_pac       <= BCD_BLANK;
            data_setup_ok <= 1'b0;
            entry_err     <= 1'b0;
        end else begin
            state         <= state_nxt;
            k             <= k_nxt;
            setup_on_q    <= setup_on;
            entry_err     <= reject;
            data_setup_ok <= commit;
            // Committed values land together with the ok pulse
            if (commit) begin
                bip_status   <= sh_status_nxt;
                bip_time     <= sh_bt_nxt;
                tranca_time  <= sh_tt_nxt;
                senha_master <= sh_master_nxt;
                senha_user   <= sh_user_nxt;
            end
            display_en <= (state_nxt != ST_IDLE) && (state_nxt != ST_COMMIT);
            bcd_pac    <= make_bcd(state_nxt, k_nxt, sh_status_nxt, sh_bt_nxt, sh_tt_nxt);
        end
    end

    // Session shadow copy; reloaded at every session start, so it needs no reset
    always_ff @(posedge clk) begin
        sh_status <= sh_status_nxt;
        sh_bt     <= sh_bt_nxt;
        sh_tt     <= sh_tt_nxt;
        sh_master <= sh_master_nxt;
        sh_user   <= sh_user_nxt;
    end

endmodule

// File: doc/setup_multi.md
SETUP_MULTI -- requirements
Module: setup_multi

Interface
REQ-001 Parameter N_USERS, default 4, number of user password slots (legal 1..8).
REQ-002 Parameter PW_MIN, default 4, minimum password length in digits; PW_MAX, default 12, maximum (PW_MAX <= 20).
REQ-003 Parameter T_MIN, default 5, and T_MAX, default 60: legal range in seconds for bip_time and tranca_time.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 setup_on  in  1  level; high = setup session requested.
REQ-007 digitos_value  in  senhaPac_t (20x4)  entered digits, digits[0] = most recent; 0xF = empty.
REQ-008 digitos_valid  in  1  one-cycle strobe qualifying digitos_value.
REQ-009 display_en  out  1  high while a session is active.
REQ-010 bcd_pac  out  bcdPac_t (6x4)  display data.
REQ-011 bip_status  out  1; bip_time  out  6; tranca_time  out  6; committed values.
REQ-012 senha_master  out  senhaPac_t; senha_user  out  N_USERS x senhaPac_t; committed passwords.
REQ-013 data_setup_ok  out  1  one-cycle pulse when a session commits.
REQ-014 entry_err  out  1  one-cycle pulse when an entry is rejected.

Function
REQ-015 FSM states IDLE, BIP_ST, BIP_T, TRANCA_T, MASTER, USER(k=0..N_USERS-1), COMMIT; IDLE->BIP_ST on setup_on rising edge, shadow registers loaded from committed outputs in that cycle.
REQ-016 Each accepted digitos_valid advances one state (BIP_ST->BIP_T->TRANCA_T->MASTER->USER0..USER(N-1)->COMMIT) on the following edge; rejected entry: state unchanged, entry_err pulses the next cycle.
REQ-017 Entry length = count of contiguous non-0xF digits from digits[0]; any digit 0xA..0xE within the length -> reject.
REQ-018 Length 0 in any state = keep current shadow value and advance (accepted).
REQ-019 BIP_ST: length 1, digit 0 or 1 -> shadow bip_status; else reject.
REQ-020 BIP_T/TRANCA_T: length 1..2, value = digits[1]*10+digits[0], accepted only if T_MIN <= value <= T_MAX.
REQ-021 MASTER: length PW_MIN..PW_MAX accepted; stored with digits beyond length forced to 0xF.
REQ-022 USER(k): length PW_MIN..PW_MAX accepted; single digit 0 (length 1) clears slot k to all 0xF (disabled), accepted.
REQ-023 COMMIT: shadow copied to committed outputs, data_setup_ok high exactly this one cycle, then IDLE even if setup_on still high; new session needs setup_on low then high.
REQ-024 setup_on low in any non-IDLE state: next state IDLE, shadow discarded, no ok pulse, committed outputs unchanged.
REQ-025 digitos_valid in IDLE or COMMIT ignored.
REQ-026 display_en = 1 in BIP_ST..USER(N-1), else 0.
REQ-027 bcd_pac while display_en: BCD5 = item code (1 BIP_ST, 2 BIP_T, 3 TRANCA_T, 4 MASTER, 5 USER), BCD4 = k+1 in USER else 0, BCD3..BCD2 = 0xF, BCD1..BCD0 = shadow value in decimal (bip_status in BCD0, BCD1 = 0) or 0xF,0xF for password states; all 0xF otherwise.

Reset
REQ-028 rst low: FSM IDLE, bip_status=1, bip_time=5, tranca_time=5, senha_master = 1,2,3,4 (digits[3..0]) rest 0xF, all senha_user all 0xF, display_en=0, bcd_pac all 0xF, data_setup_ok=0, entry_err=0.
REQ-029 Reset mid-session discards shadow and restores REQ-028 values immediately (asynchronous).

Configuration
REQ-030 SETUP_DUP_CHECK_EN defined: USER(k) entry equal to shadow master or to any other non-disabled shadow user slot rejected with entry_err; undefined: no duplicate check, such entries accepted.

Structure
REQ-031 Package fechadura_pkg holds bcdPac_t, senhaPac_t, DIGIT_EMPTY (0xF), item-code constants and FSM state enum.
REQ-032 Sub-module setup_pw_check: combinational length count, invalid-digit flag, tail masking to 0xF; instantiated once.

Verification
REQ-033 Reset release, no stimulus -> bip_time=5, tranca_time=5, master digits[3..0]=1,2,3,4, users empty, bcd_pac=0xFFFFFF.
REQ-034 Session: 1; 30; 45; master 9876; users 1111,2222,3333,4444 -> ok pulse once, bip_time=30, tranca_time=45, senha_user[2] digits[3..0]=3,3,3,3.
REQ-035 BIP_T entry 61, then 4, then 20 -> two entry_err pulses, bip_time 20 after commit.
REQ-036 MASTER entry 123 (len 3) and 13-digit entry -> both rejected, state stays MASTER, BCD5=4.
REQ-037 setup_on dropped in USER1 after new master 5555 -> no ok pulse, master still 1,2,3,4, display_en 0 next cycle.
REQ-038 With SETUP_DUP_CHECK_EN, user0 = master value -> entry_err; without macro -> accepted.
